// File: rtl/mem_uart_streamer.sv
// Streams `length` bytes of a word-addressed RAM region, starting at `base_addr`, out of a UART TX valid/ack handshake.
// Define MEM_UART_STREAMER_CHECKSUM_EN to append a mod-256 checksum byte to each run.
module mem_uart_streamer #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 16,
    parameter int RD_LAT    = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              uart_valid,
    output logic [7:0]        uart_data,
    input  logic              uart_ack
);
    localparam int BPW    = DATA_W / 8;
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BPW - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_FINISH
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
        , S_CKSUM
`endif
    } state_t;

`ifdef MEM_UART_STREAMER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CKSUM;
`else
    localparam state_t S_TAIL = S_FINISH;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_left;
    logic [LANE_W-1:0]   r_lane;
    logic [LAT_W-1:0]    r_lat;
    logic [DATA_W-1:0]   r_word;
    logic [LANE_W-1:0]   w_lane_idx;
    logic [7:0]          w_byte;
    logic                w_last_byte;
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
    logic [7:0]          r_sum;
`endif

    assign w_last_byte = (r_left == LEN_W'(1));

    // Physical lane = logical lane index, mirrored when the top lane goes first.
    always_comb begin
        w_lane_idx = (MSB_FIRST != 0) ? (LANE_LAST - r_lane) : r_lane;
        w_byte     = '0;
        for (int unsigned i = 0; i < BPW; i++) begin
            if (w_lane_idx == LANE_W'(i)) begin
                w_byte = r_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = (length == '0) ? S_TAIL : S_READ;
            S_READ:   if (r_lat == LAT_LAST) w_next = S_SEND;
            S_SEND: begin
                if (uart_ack) begin
                    if (w_last_byte)              w_next = S_TAIL;
                    else if (r_lane == LANE_LAST) w_next = S_READ;
                end
            end
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
            S_CKSUM:  if (uart_ack) w_next = S_FINISH;
`endif
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        uart_valid = 1'b0;
        uart_data  = '0;
        mem_addr   = r_addr;
        case (r_state)
            S_READ:   busy = 1'b1;
            S_SEND: begin
                busy       = 1'b1;
                uart_valid = 1'b1;
                uart_data  = w_byte;
            end
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
            S_CKSUM: begin
                busy       = 1'b1;
                uart_valid = 1'b1;
                uart_data  = r_sum;
            end
`endif
            S_FINISH: done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_left <= '0;
            r_lane <= '0;
            r_lat  <= '0;
            r_word <= '0;
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
            r_sum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr <= base_addr;
                        r_left <= length;
                        r_lane <= '0;
                        r_lat  <= '0;
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
                        r_sum  <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (r_lat == LAT_LAST) begin
                        r_word <= mem_data;
                        r_lat  <= '0;
                    end else begin
                        r_lat  <= r_lat + LAT_W'(1);
                    end
                end
                S_SEND: begin
                    if (uart_ack) begin
                        r_left <= r_left - LEN_W'(1);
`ifdef MEM_UART_STREAMER_CHECKSUM_EN
                        r_sum  <= r_sum + w_byte;
`endif
                        // On the final byte the address is left where the run ended.
                        if (!w_last_byte) begin
                            if (r_lane == LANE_LAST) begin
                                r_lane <= '0;
                                r_addr <= r_addr + ADDR_W'(1);
                            end else begin
                                r_lane <= r_lane + LANE_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_uart_streamer.sv
// Directed, table-driven bench for mem_uart_streamer: three instances (default, MSB_FIRST=1, RD_LAT=2)
// share stimulus; each vector is checked against one chosen instance.
`timescale 1ns/1ps
module tb_mem_uart_streamer;

`ifdef MEM_UART_STREAMER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef struct {
        int          inst;
        logic [13:0] base;
        logic [15:0] len;
        int          restart;
        int          nexp;
        logic [7:0]  eb [6];
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [13:0]       base_addr;
    logic [15:0]       length;
    logic              uart_ack;
    logic [2:0]        o_v;
    logic [2:0]        o_dn;
    logic [2:0]        o_bz;
    logic [2:0][7:0]   o_d;
    logic [2:0][13:0]  o_ma;
    logic [2:0][15:0]  o_md;
    logic [15:0]       r_md2;
    logic [15:0]       ram [0:16383];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT=1 instances see a combinational read; the RD_LAT=2 instance sees one register stage.
    assign o_md[0] = ram[o_ma[0]];
    assign o_md[1] = ram[o_ma[1]];
    always_ff @(posedge clk) r_md2 <= ram[o_ma[2]];
    assign o_md[2] = r_md2;

    mem_uart_streamer u_def (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(o_bz[0]), .done(o_dn[0]), .mem_addr(o_ma[0]), .mem_data(o_md[0]),
        .uart_valid(o_v[0]), .uart_data(o_d[0]), .uart_ack(uart_ack)
    );

    mem_uart_streamer #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(o_bz[1]), .done(o_dn[1]), .mem_addr(o_ma[1]), .mem_data(o_md[1]),
        .uart_valid(o_v[1]), .uart_data(o_d[1]), .uart_ack(uart_ack)
    );

    mem_uart_streamer #(.RD_LAT(2)) u_lat (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(o_bz[2]), .done(o_dn[2]), .mem_addr(o_ma[2]), .mem_data(o_md[2]),
        .uart_valid(o_v[2]), .uart_data(o_d[2]), .uart_ack(uart_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0]  got [$];
        logic [13:0] gaddr [$];
        logic [7:0]  exp [$];
        logic [7:0]  sum;
        int          lat, first_k, done_k, done_n, words;
        lat     = (v.inst == 2) ? 2 : 1;
        sum     = 8'h00;
        first_k = 0;
        done_k  = 0;
        done_n  = 0;
        for (int i = 0; i < v.nexp; i++) begin
            exp.push_back(v.eb[i]);
            sum = sum + v.eb[i];
        end
        if (CK != 0) exp.push_back(sum);

        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        length    = v.len;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == v.restart);
            if (k == 1)
                check($sformatf("v%0d_busy_after_start", idx), 32'(o_bz[v.inst]),
                      32'((v.len != 16'd0) || (CK != 0)));
            if (o_v[v.inst]) begin
                if (first_k == 0) first_k = k;
                if (uart_ack) begin
                    got.push_back(o_d[v.inst]);
                    gaddr.push_back(o_ma[v.inst]);
                end
            end
            if (o_dn[v.inst]) begin
                done_n++;
                done_k = k;
                check($sformatf("v%0d_busy_in_done", idx), 32'(o_bz[v.inst]), 32'd0);
            end
        end
        start = 1'b0;

        check($sformatf("v%0d_byte_count", idx), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size())
                check($sformatf("v%0d_byte%0d", idx, i), 32'(got[i]), 32'(exp[i]));
        for (int i = 0; i < v.nexp; i++)
            if (i < gaddr.size())
                check($sformatf("v%0d_addr%0d", idx, i), 32'(gaddr[i]), 32'(14'(v.base + 14'(i / 2))));
        check($sformatf("v%0d_done_count", idx), 32'(done_n), 32'd1);
        words = (int'(v.len) + 1) / 2;
        check($sformatf("v%0d_done_cycle", idx), 32'(done_k), 32'(words * lat + int'(v.len) + 1 + CK));
        if (v.len != 16'd0)
            check($sformatf("v%0d_first_valid_cycle", idx), 32'(first_k), 32'(lat + 1));
    endtask

    initial begin
        logic [7:0] sgot [$];

        for (int i = 0; i < 16384; i++) ram[i] = '0;
        ram[14'h0010] = 16'hBEEF;
        ram[14'h0011] = 16'h1234;
        ram[14'h0012] = 16'h5678;
        ram[14'h3FFF] = 16'hA1B2;
        ram[14'h0000] = 16'hC3D4;

        vecs[0] = '{inst: 0, base: 14'h0010, len: 16'd4, restart: 0, nexp: 4,
                    eb: '{8'hEF, 8'hBE, 8'h34, 8'h12, 8'h00, 8'h00}};
        vecs[1] = '{inst: 1, base: 14'h0010, len: 16'd3, restart: 0, nexp: 3,
                    eb: '{8'hBE, 8'hEF, 8'h12, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{inst: 2, base: 14'h3FFF, len: 16'd4, restart: 0, nexp: 4,
                    eb: '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'h00, 8'h00}};
        vecs[3] = '{inst: 0, base: 14'h0010, len: 16'd6, restart: 3, nexp: 6,
                    eb: '{8'hEF, 8'hBE, 8'h34, 8'h12, 8'h78, 8'h56}};
        vecs[4] = '{inst: 0, base: 14'h0010, len: 16'd0, restart: 0, nexp: 0,
                    eb: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{inst: 2, base: 14'h0011, len: 16'd1, restart: 0, nexp: 1,
                    eb: '{8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        uart_ack  = 1'b1;
        #1;
        check("reset_valid", 32'(o_v[0]), 32'd0);
        check("reset_data", 32'(o_d[0]), 32'd0);
        check("reset_busy", 32'(o_bz[0]), 32'd0);
        check("reset_done", 32'(o_dn[0]), 32'd0);
        check("reset_addr", 32'(o_ma[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

        // Ack stall: first byte must be held stable while ack is low.
        uart_ack = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 14'h0010;
        length    = 16'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && !o_v[0]; k++) @(negedge clk);
        check("stall_valid_seen", 32'(o_v[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_valid_c%0d", k), 32'(o_v[0]), 32'd1);
            check($sformatf("stall_data_c%0d", k), 32'(o_d[0]), 32'hEF);
        end
        uart_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (o_v[0] && uart_ack) sgot.push_back(o_d[0]);
            @(negedge clk);
        end
        check("stall_byte_count", 32'(sgot.size()), 32'(2 + CK));
        if (sgot.size() >= 2) begin
            check("stall_byte0", 32'(sgot[0]), 32'hEF);
            check("stall_byte1", 32'(sgot[1]), 32'hBE);
        end
        repeat (30) @(negedge clk);

        // Reset mid-stream after the first byte has been accepted.
        start     = 1'b1;
        base_addr = 14'h0010;
        length    = 16'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst_first_valid", 32'(o_v[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_v[0]), 32'd0);
        check("midrst_data", 32'(o_d[0]), 32'd0);
        check("midrst_busy", 32'(o_bz[0]), 32'd0);
        check("midrst_addr", 32'(o_ma[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst_no_done_c%0d", k), 32'(o_dn[0]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(6, vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
